// File: rtl/router_chk_pkg.sv
// Shared types, error indices and header field helpers for router_protocol_checker.
package router_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2,
    ST_ABORT   = 2'd3
  } state_e;

  localparam int unsigned NUM_ERR     = 6;
  localparam int unsigned ERR_LEN     = 0;
  localparam int unsigned ERR_PARITY  = 1;
  localparam int unsigned ERR_ADDR    = 2;
  localparam int unsigned ERR_HOLD    = 3;
  localparam int unsigned ERR_TIMEOUT = 4;
  localparam int unsigned ERR_ROUTE   = 5;

  localparam int unsigned HDR_MAX_W  = 32;
  localparam int unsigned HDR_ADDR_W = 2;

  // Header layout is {len, addr[1:0]}; callers zero-extend the byte to HDR_MAX_W.
  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr);
    return HDR_ADDR_W'(hdr);
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr);
    return hdr >> HDR_ADDR_W;
  endfunction

endpackage

// File: rtl/router_chk_if.sv
// Router-side signals observed by the checker plus the checker's status outputs.
interface router_chk_if
  import router_chk_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 8
);
  logic                pkt_valid;
  logic [DATA_W-1:0]   data_in;
  logic                busy;
  logic [NUM_CH-1:0]   valid_out;
  logic [NUM_CH-1:0]   read_enable;
  logic                err_clr;
  logic [NUM_ERR-1:0]  err_flags;
  logic                err_any;
  logic [15:0]         err_count;
  logic [15:0]         pkt_count;

  modport master (
    output pkt_valid, data_in, busy, valid_out, read_enable, err_clr,
    input  err_flags, err_any, err_count, pkt_count
  );

  modport slave (
    input  pkt_valid, data_in, busy, valid_out, read_enable, err_clr,
    output err_flags, err_any, err_count, pkt_count
  );
endinterface

// File: rtl/router_chk_timeout.sv
// Per-channel read timeout: counts stalled cycles, pulses once when the limit is reached.
module router_chk_timeout #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic valid_i,
  input  logic read_i,
  output logic expire_c_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_c;

  assign stall_c = valid_i & ~read_i;

  // Count saturates at the limit so the pulse fires only once per stall episode.
  always_comb begin
    cnt_d      = cnt_q;
    expire_c_o = 1'b0;
    if (!stall_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d      = cnt_q + CNT_W'(1);
      expire_c_o = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/router_protocol_checker.sv
// Passive router protocol checker: packet FSM, hold/timeout/route timing, sticky error flags.
// Optional feature macro: ROUTER_CHK_ASSERT_EN adds named SVA per error event.
module router_protocol_checker
  import router_chk_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_TIMEOUT = 30,
  parameter int unsigned ROUTE_LAT    = 3
) (
  input  logic        clock,
  input  logic        resetn,
  router_chk_if.slave bus
);
  localparam int unsigned AW    = $clog2(NUM_CH);
  localparam int unsigned LEN_W = DATA_W - 2;
  localparam int unsigned RT_W  = $clog2(ROUTE_LAT + 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, cnt_inc_c, hdr_len_c;
  logic [DATA_W-1:0]   par_q, par_d, data_q;
  logic                busy_q;
  logic [HDR_ADDR_W-1:0] hdr_addr_c;
  logic                arm_c, pkt_done_c, accept_c;
  logic                route_armed_q, route_armed_d, ev_route_c;
  logic [RT_W-1:0]     route_cnt_q, route_cnt_d;
  logic [AW-1:0]       route_addr_q, route_addr_d;
  logic [NUM_CH-1:0]   tmo_c;
  logic [NUM_ERR-1:0]  ev_fsm_c, ev_c, flags_q, flags_d;
  logic                any_q;
  logic [15:0]         err_cnt_q, err_cnt_d, pkt_cnt_q, pkt_cnt_d;

  assign accept_c   = ~bus.busy;
  assign hdr_len_c  = LEN_W'(hdr_len(HDR_MAX_W'(bus.data_in)));
  assign hdr_addr_c = hdr_addr(HDR_MAX_W'(bus.data_in));
  assign cnt_inc_c  = cnt_q + LEN_W'(1);

  // Packet FSM: header decode, payload length/parity tracking.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    arm_c      = 1'b0;
    pkt_done_c = 1'b0;
    ev_fsm_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && bus.pkt_valid) begin
          len_d = hdr_len_c;
          cnt_d = '0;
          par_d = bus.data_in;
          if (32'(hdr_addr_c) >= NUM_CH) begin
            ev_fsm_c[ERR_ADDR] = 1'b1;
            state_d            = ST_ABORT;
          end else begin
            arm_c   = 1'b1;
            state_d = (hdr_len_c == '0) ? ST_PARITY : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept_c) begin
          if (bus.pkt_valid) begin
            cnt_d = cnt_inc_c;
            par_d = par_q ^ bus.data_in;
            if (cnt_inc_c == len_q) state_d = ST_PARITY;
          end else begin
            ev_fsm_c[ERR_LEN] = 1'b1;
            state_d           = ST_IDLE;
          end
        end
      end
      ST_PARITY: begin
        if (accept_c) begin
          if (!bus.pkt_valid) begin
            ev_fsm_c[ERR_PARITY] = (bus.data_in != par_q);
            pkt_done_c           = 1'b1;
            state_d              = ST_IDLE;
          end else begin
            ev_fsm_c[ERR_LEN] = 1'b1;
            state_d           = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        if (!bus.pkt_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Route timer: destination FIFO must go non-empty within ROUTE_LAT cycles of the header.
  always_comb begin
    route_armed_d = route_armed_q;
    route_cnt_d   = route_cnt_q;
    route_addr_d  = route_addr_q;
    ev_route_c    = 1'b0;
    if (arm_c) begin
      route_armed_d = 1'b1;
      route_cnt_d   = '0;
      route_addr_d  = AW'(hdr_addr_c);
    end else if (route_armed_q) begin
      if (bus.valid_out[route_addr_q]) begin
        route_armed_d = 1'b0;
      end else if (route_cnt_q == RT_W'(ROUTE_LAT - 1)) begin
        ev_route_c    = 1'b1;
        route_armed_d = 1'b0;
      end else begin
        route_cnt_d = route_cnt_q + RT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tmo
    router_chk_timeout #(.TIMEOUT(READ_TIMEOUT)) u_tmo (
      .clock      (clock),
      .resetn     (resetn),
      .valid_i    (bus.valid_out[g]),
      .read_i     (bus.read_enable[g]),
      .expire_c_o (tmo_c[g])
    );
  end

  // Event merge and sticky accumulation; a same-cycle event beats err_clr.
  always_comb begin
    ev_c              = ev_fsm_c;
    ev_c[ERR_HOLD]    = (state_q != ST_IDLE) && busy_q && (bus.data_in != data_q);
    ev_c[ERR_TIMEOUT] = |tmo_c;
    ev_c[ERR_ROUTE]   = ev_route_c;
    flags_d   = (bus.err_clr ? '0 : flags_q) | ev_c;
    err_cnt_d = err_cnt_q;
    if (bus.err_clr)
      err_cnt_d = (|ev_c) ? 16'd1 : 16'd0;
    else if ((|ev_c) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
    pkt_cnt_d = pkt_cnt_q + 16'(pkt_done_c);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      par_q         <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      route_armed_q <= 1'b0;
      route_cnt_q   <= '0;
      route_addr_q  <= '0;
      flags_q       <= '0;
      any_q         <= 1'b0;
      err_cnt_q     <= '0;
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      par_q         <= par_d;
      data_q        <= bus.data_in;
      busy_q        <= bus.busy;
      route_armed_q <= route_armed_d;
      route_cnt_q   <= route_cnt_d;
      route_addr_q  <= route_addr_d;
      flags_q       <= flags_d;
      any_q         <= |flags_d;
      err_cnt_q     <= err_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  assign bus.err_flags = flags_q;
  assign bus.err_any   = any_q;
  assign bus.err_count = err_cnt_q;
  assign bus.pkt_count = pkt_cnt_q;

`ifdef ROUTER_CHK_ASSERT_EN
  a_len:     assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_LEN])
    else $error("router_chk: packet length violation");
  a_parity:  assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_PARITY])
    else $error("router_chk: parity violation");
  a_addr:    assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_ADDR])
    else $error("router_chk: bad destination address");
  a_hold:    assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_HOLD])
    else $error("router_chk: data changed while busy");
  a_timeout: assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_TIMEOUT])
    else $error("router_chk: read timeout");
  a_route:   assert property (@(posedge clock) disable iff (!resetn) !ev_c[ERR_ROUTE])
    else $error("router_chk: route latency exceeded");
`endif

endmodule

// File: tb/tb_router_protocol_checker.sv
// Directed bench for router_protocol_checker (NUM_CH=3, DATA_W=8, READ_TIMEOUT=30, ROUTE_LAT=3).
module tb_router_protocol_checker;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_tot  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  router_chk_if #(.NUM_CH(3), .DATA_W(8)) bus ();

  router_protocol_checker #(
    .NUM_CH(3), .DATA_W(8), .READ_TIMEOUT(30), .ROUTE_LAT(3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic pv, input logic [7:0] d);
    bus.pkt_valid = pv;
    bus.data_in   = d;
    bus.busy      = 1'b0;
    step();
  endtask

  task automatic clr();
    bus.err_clr = 1'b1;
    send(1'b0, 8'h00);
    bus.err_clr = 1'b0;
  endtask

  task automatic good_pkt();
    send(1'b1, 8'h0C);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    send(1'b0, 8'h0C);
  endtask

  initial begin
    bus.pkt_valid   = 1'b0;
    bus.data_in     = 8'h00;
    bus.busy        = 1'b0;
    bus.valid_out   = 3'b000;
    bus.read_enable = 3'b000;
    bus.err_clr     = 1'b0;
    step();
    step();
    chk("rst_flags", 32'(bus.err_flags), 32'h0);
    chk("rst_any",   32'(bus.err_any),   32'h0);
    chk("rst_ecnt",  32'(bus.err_count), 32'h0);
    chk("rst_pcnt",  32'(bus.pkt_count), 32'h0);
    resetn          = 1'b1;
    bus.valid_out   = 3'b111;
    bus.read_enable = 3'b111;
    step();

    // Clean packet, then the same packet with a stable-data stall mid-payload
    good_pkt();
    chk("ok_flags", 32'(bus.err_flags), 32'h0);
    chk("ok_pcnt",  32'(bus.pkt_count), 32'd1);
    send(1'b1, 8'h0C);
    send(1'b1, 8'h01);
    bus.busy = 1'b1; bus.data_in = 8'h02;
    step(); step(); step();
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    send(1'b0, 8'h0C);
    chk("stall_flags", 32'(bus.err_flags), 32'h0);
    chk("stall_pcnt",  32'(bus.pkt_count), 32'd2);

    // Bad parity byte
    send(1'b1, 8'h0C);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    chk("par_flags", 32'(bus.err_flags), 32'h02);
    chk("par_any",   32'(bus.err_any),   32'h1);
    chk("par_ecnt",  32'(bus.err_count), 32'd1);
    chk("par_pcnt",  32'(bus.pkt_count), 32'd3);
    clr();
    chk("clr_flags", 32'(bus.err_flags), 32'h0);
    chk("clr_ecnt",  32'(bus.err_count), 32'd0);

    // Short packet: pkt_valid drops after two of three payload bytes
    send(1'b1, 8'h0D);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b0, 8'h55);
    chk("len_flags", 32'(bus.err_flags), 32'h01);
    good_pkt();
    chk("len_idle_ecnt", 32'(bus.err_count), 32'd1);
    chk("len_idle_pcnt", 32'(bus.pkt_count), 32'd4);
    clr();

    // Out-of-range address, trailing bytes ignored until pkt_valid drops
    send(1'b1, 8'h07);
    chk("addr_flags", 32'(bus.err_flags), 32'h04);
    send(1'b1, 8'h55);
    send(1'b1, 8'hAA);
    send(1'b0, 8'h00);
    good_pkt();
    chk("addr_ecnt", 32'(bus.err_count), 32'd1);
    chk("addr_pcnt", 32'(bus.pkt_count), 32'd5);
    clr();

    // Destination never becomes valid: route latency exceeded on the third edge
    bus.valid_out = 3'b000;
    send(1'b1, 8'h0C);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    chk("route_early", 32'(bus.err_flags), 32'h0);
    send(1'b1, 8'h03);
    chk("route_flags", 32'(bus.err_flags), 32'h20);
    send(1'b0, 8'h0C);
    chk("route_pcnt", 32'(bus.pkt_count), 32'd6);
    clr();

    // Channel 2 valid without reads; err_clr on the expiry edge loses to the event
    bus.valid_out   = 3'b111;
    bus.read_enable = 3'b011;
    for (int i = 0; i < 29; i++) step();
    chk("tmo_early", 32'(bus.err_flags), 32'h0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("tmo_flags", 32'(bus.err_flags), 32'h10);
    chk("tmo_ecnt",  32'(bus.err_count), 32'd1);
    step();
    chk("tmo_once",  32'(bus.err_count), 32'd1);
    bus.read_enable = 3'b111;
    clr();

    // Data changes while stalled
    send(1'b1, 8'h0C);
    send(1'b1, 8'h01);
    bus.busy = 1'b1; bus.data_in = 8'hA5;
    step();
    bus.data_in = 8'h5A;
    step();
    chk("hold_flags", 32'(bus.err_flags), 32'h08);

    // Reset mid-packet clears everything; restart is clean
    resetn = 1'b0;
    #1;
    chk("mrst_flags", 32'(bus.err_flags), 32'h0);
    chk("mrst_any",   32'(bus.err_any),   32'h0);
    chk("mrst_ecnt",  32'(bus.err_count), 32'h0);
    chk("mrst_pcnt",  32'(bus.pkt_count), 32'h0);
    bus.busy = 1'b0; bus.pkt_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    step();
    good_pkt();
    chk("restart_flags", 32'(bus.err_flags), 32'h0);
    chk("restart_ecnt",  32'(bus.err_count), 32'd0);
    chk("restart_pcnt",  32'(bus.pkt_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
